// File: rtl/hdmi_video_timing.sv
// Raster timing generator and pixel source feeding the three TMDS encoders.
// Define HDMI_TEST_PATTERN_EN for internal colour bars instead of r_in/g_in/b_in.
module hdmi_video_timing #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [1:0]  cd_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_act;
    logic        active;
    logic        hs_lvl;
    logic        vs_lvl;
    logic [7:0]  src_r;
    logic [7:0]  src_g;
    logic [7:0]  src_b;

    always_comb begin
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        h_act  = (hcnt < H_ACT);
        active = h_act && (vcnt < V_ACT);
        hs_lvl = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_lvl = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= 12'd0;
            vcnt <= 12'd0;
        end else if (h_wrap) begin
            hcnt <= 12'd0;
            vcnt <= v_wrap ? 12'd0 : vcnt + 12'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    assign pix_x = hcnt;
    assign pix_y = vcnt;

`ifdef HDMI_TEST_PATTERN_EN
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [2:0]  bar;
    logic [11:0] bar_pix;
    logic        unused_in;

    assign unused_in = ^{r_in, g_in, b_in};

    // bar/bar_pix always describe the pixel at the current hcnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar     <= 3'd0;
            bar_pix <= 12'd0;
        end else if (h_wrap) begin
            bar     <= 3'd0;
            bar_pix <= 12'd0;
        end else if (h_act) begin
            if (bar_pix == BAR_LAST) begin
                bar_pix <= 12'd0;
                bar     <= bar + 3'd1;
            end else begin
                bar_pix <= bar_pix + 12'd1;
            end
        end
    end

    // white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        src_r = {8{~bar[1]}};
        src_g = {8{~bar[2]}};
        src_b = {8{~bar[0]}};
    end
`else
    always_comb begin
        src_r = r_in;
        src_g = g_in;
        src_b = b_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            vde         <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            cd_blue     <= 2'b00;
        end else begin
            red         <= active ? src_r : 8'h00;
            green       <= active ? src_g : 8'h00;
            blue        <= active ? src_b : 8'h00;
            vde         <= active;
            frame_start <= (hcnt == 12'd0) && (vcnt == 12'd0);
            hsync       <= hs_lvl;
            vsync       <= vs_lvl;
            cd_blue     <= {vs_lvl, hs_lvl};
        end
    end

endmodule
